// File: rtl/crono_vga_pkg.sv
// Shared definitions for the chrono-display register sequencer: FSM state
// encoding, field indices, default RTC chrono addresses and a one-hot decoder.
package crono_vga_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    CAPT = 3'd3,
    NEXT = 3'd4
  } estado_t;

  localparam logic [1:0] CAMPO_SEG     = 2'd0;
  localparam logic [1:0] CAMPO_MIN     = 2'd1;
  localparam logic [1:0] CAMPO_HORA    = 2'd2;
  localparam logic [1:0] CAMPO_NINGUNO = 2'd3;

  localparam logic [7:0] DIR_SEG_DEF  = 8'h21;
  localparam logic [7:0] DIR_MIN_DEF  = 8'h22;
  localparam logic [7:0] DIR_HORA_DEF = 8'h23;

  // Field index to {hora,min,seg} enable; "none" yields no enable.
  function automatic logic [2:0] onehot3(input logic [1:0] campo);
    logic [2:0] r;
    r = '0;
    case (campo)
      CAMPO_SEG:  r = 3'b001;
      CAMPO_MIN:  r = 3'b010;
      CAMPO_HORA: r = 3'b100;
      default:    r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/contador_timeout_crono.sv
// 8-bit clearable wait counter; expira flags that TIMEOUT-1 cycles have elapsed.
module contador_timeout_crono #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expira
);

  localparam logic [7:0] LIMITE = 8'(TIMEOUT - 1);

  logic [7:0] cuenta;

  // Count cycles spent waiting; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (reset)
      cuenta <= '0;
    else if (clr)
      cuenta <= '0;
    else if (en)
      cuenta <= cuenta + 8'd1;
  end

  assign expira = (cuenta == LIMITE);

endmodule

// File: rtl/control_registros_crono_vga.sv
// Sequences capture of the chrono seconds/minutes/hours display registers:
// reads each field from the RTC in RTC mode, or steers EN_deco to the field
// under edit in user mode.
module control_registros_crono_vga
  import crono_vga_pkg::*;
#(
  parameter logic [7:0]  DIR_SEG  = DIR_SEG_DEF,
  parameter logic [7:0]  DIR_MIN  = DIR_MIN_DEF,
  parameter logic [7:0]  DIR_HORA = DIR_HORA_DEF,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       seleccion,
  input  logic       inicio,
  input  logic       listo,
  input  logic [1:0] campo_usr,
  output logic [7:0] direccion,
  output logic       leer,
  output logic       EN,
  output logic [2:0] EN_deco,
  output logic       ocupado,
  output logic       error_to
);

  estado_t    estado, estado_d;
  logic [1:0] indice, indice_d;
  logic [7:0] direccion_d;
  logic       leer_d, EN_d, ocupado_d, error_to_d;
  logic [2:0] EN_deco_d;
  logic       cnt_clr, cnt_en, expira;

  contador_timeout_crono #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expira (expira)
  );

  // State, field index and every output are registered together; the
  // combinational block below computes their next values.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado    <= IDLE;
      indice    <= CAMPO_SEG;
      direccion <= '0;
      leer      <= 1'b0;
      EN        <= 1'b0;
      EN_deco   <= '0;
      ocupado   <= 1'b0;
      error_to  <= 1'b0;
    end else begin
      estado    <= estado_d;
      indice    <= indice_d;
      direccion <= direccion_d;
      leer      <= leer_d;
      EN        <= EN_d;
      EN_deco   <= EN_deco_d;
      ocupado   <= ocupado_d;
      error_to  <= error_to_d;
    end
  end

  // Next-state and next-output logic; strobes default low, held values hold.
  always_comb begin
    estado_d    = estado;
    indice_d    = indice;
    direccion_d = direccion;
    leer_d      = 1'b0;
    EN_d        = 1'b0;
    EN_deco_d   = '0;
    ocupado_d   = ocupado;
    error_to_d  = error_to;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    if (estado != IDLE && seleccion) begin
      // Switching to user edit abandons the refresh without any capture.
      estado_d  = IDLE;
      ocupado_d = 1'b0;
    end else begin
      case (estado)
        IDLE: begin
          if (seleccion) begin
            EN_deco_d = onehot3(campo_usr);
          end else if (inicio) begin
            indice_d   = CAMPO_SEG;
            error_to_d = 1'b0;
            ocupado_d  = 1'b1;
            estado_d   = REQ;
          end
        end
        REQ: begin
          case (indice)
            CAMPO_SEG: direccion_d = DIR_SEG;
            CAMPO_MIN: direccion_d = DIR_MIN;
            default:   direccion_d = DIR_HORA;
          endcase
          leer_d   = 1'b1;
          cnt_clr  = 1'b1;
          estado_d = WAIT;
        end
        WAIT: begin
          // A ready arriving on the expiry cycle still captures the field.
          if (listo) begin
            estado_d = CAPT;
          end else if (expira) begin
            error_to_d = 1'b1;
            estado_d   = NEXT;
          end else begin
            cnt_en = 1'b1;
          end
        end
        CAPT: begin
          EN_d      = 1'b1;
          EN_deco_d = onehot3(indice);
          estado_d  = NEXT;
        end
        NEXT: begin
          if (indice == CAMPO_HORA) begin
            ocupado_d = 1'b0;
            estado_d  = IDLE;
          end else begin
            indice_d = indice + 2'd1;
            estado_d = REQ;
          end
        end
        default: estado_d = IDLE;
      endcase
    end
  end

endmodule

// File: doc/control_registros_crono_vga.md
Name: control_registros_crono_vga

Overview:
- Sequences capture of the chronometer seconds, minutes and hours display registers that feed the VGA text overlay.
- In RTC mode (seleccion=0) it reads the three chronometer fields from the RTC interface in turn.
  - For each field it drives the address and a read request, waits for the ready handshake, then pulses EN together with that field's one-hot EN_deco.
- In user-edit mode (seleccion=1) it only steers EN_deco to the field being edited; the user path's ACT strobe performs the capture inside each register.

Parameters:
- DIR_SEG, 8'h21, RTC address of chrono seconds.
- DIR_MIN, 8'h22, RTC address of chrono minutes.
- DIR_HORA, 8'h23, RTC address of chrono hours.
- TIMEOUT, 255, max cycles to wait for listo per field (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- seleccion  in  1  0 = RTC refresh mode, 1 = user-edit mode
- inicio  in  1  refresh request pulse (e.g. 1 Hz tick)
- listo  in  1  RTC read data valid; data held stable until next leer
- campo_usr  in  2  field under edit: 0 = seg, 1 = min, 2 = hora, 3 = none
- direccion  out  8  RTC register address
- leer  out  1  one-cycle read request
- EN  out  1  one-cycle capture strobe to registers (RTC mode)
- EN_deco  out  3  one-hot field enable {hora,min,seg}
- ocupado  out  1  high while a refresh sequence is active
- error_to  out  1  sticky timeout flag

Behaviour:
- Reset values: direccion=0, leer=0, EN=0, EN_deco=000, ocupado=0, error_to=0; FSM=IDLE, field index=0, timeout counter=0. Reset applies at any state, mid-sequence included.
- All outputs are registered.

FSM states: IDLE, REQ, WAIT, CAPT, NEXT.
- IDLE:
  - seleccion=1: EN_deco <= onehot(campo_usr), one-cycle latency; campo_usr=3 gives 000; EN=0.
  - seleccion=0: EN_deco=000.
  - inicio=1 with seleccion=0: index <= 0, error_to <= 0, ocupado <= 1, go to REQ.
- REQ:
  - direccion <= DIR[index], leer=1 for exactly one cycle, counter <= 0, go to WAIT.
- WAIT:
  - listo=1: go to CAPT.
  - Else counter increments; when counter reaches TIMEOUT-1 without listo: error_to <= 1, go to NEXT (field skipped, no EN).
  - listo and counter expiry in the same cycle: listo wins.
- CAPT:
  - EN=1 and EN_deco=onehot(index) for exactly one cycle; direccion held. Go to NEXT.
- NEXT:
  - EN=0, EN_deco=000.
  - index<2: index+1, go to REQ.
  - index=2: ocupado <= 0, go to IDLE.
- Sequence order is always seg, min, hora.
- Fault-free latency from inicio to hora capture: 3 × (REQ + WAIT + CAPT + NEXT) cycles, with WAIT length set by listo.
- inicio while ocupado=1 is ignored (not queued).
- seleccion going to 1 in any non-IDLE state:
  - Next edge: return to IDLE with leer=0, EN=0, EN_deco=000, ocupado=0.
  - No capture is issued. error_to is unchanged.
- listo outside WAIT is ignored.
- At most one EN_deco bit is high at any time. EN never asserts when seleccion=1.

Decomposition:
- Shared package crono_vga_pkg holds:
  - FSM state encoding (3-bit);
  - field index constants CAMPO_SEG=0, CAMPO_MIN=1, CAMPO_HORA=2, CAMPO_NINGUNO=3;
  - default RTC chrono addresses;
  - a onehot3 decode function.
- One natural sub-module: contador_timeout_crono.
  - Function: 8-bit clearable counter with expiry flag.
  - Ports: clk, reset, clr, en, expira.

Test Plan:
- RTC refresh with listo 2 cycles after each leer:
  - leer pulses with direccion 21, 22, 23.
  - EN pulses with EN_deco 001, 010, 100 in order.
  - ocupado drops after the hora capture; error_to=0.
- No listo for the min field, TIMEOUT=4:
  - error_to=1 four cycles after the min leer.
  - No EN with EN_deco=010.
  - hora is still read at 23 and captured with EN_deco=100.
- User mode, seleccion=1, campo_usr sequence 0, 1, 3, 2:
  - EN_deco follows one cycle later as 001, 010, 000, 100.
  - EN stays 0; leer stays 0.
- Abort: seleccion rises in WAIT of the min field:
  - Next cycle ocupado=0, no EN pulse, FSM in IDLE.
  - A later inicio with seleccion=0 restarts from seg (direccion=21).
- Collisions:
  - inicio during ocupado is ignored (only 3 leer pulses total).
  - listo on the exact expiry cycle captures the field with error_to=0.
- Reset asserted during CAPT of seg:
  - Next cycle all outputs are 0 and EN_deco=000.
  - inicio after reset release starts a full fresh sequence.
